// File: rtl/controle_entrada.sv
// controle_entrada: operator input handshake for the processor's IN instruction.
// Synchronizes and debounces botaoIN, then captures chaves once per request.
// Ports:
//   clock, reset         - single clock, synchronous active-high reset
//   pedido               - processor waits for operator data (level)
//   botaoIN              - raw asynchronous bouncing push button
//   chaves               - operator switch data (LARGURA_CHAVES bits)
//   dado, valido         - captured switches (zero-extended) and its flag
//   status, liberar      - halt request level and one-cycle resume pulse
module controle_entrada #(
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int LARGURA_CHAVES  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pedido,
    input  logic                      botaoIN,
    input  logic [LARGURA_CHAVES-1:0] chaves,
    output logic [31:0]               dado,
    output logic                      valido,
    output logic                      status,
    output logic                      liberar
);

    typedef enum logic [2:0] {
        OCIOSO,
        AGUARDA_PRESS,
        AGUARDA_SOLTA,
        LIBERA,
        CONCLUIDO
    } estado_t;

    localparam logic [15:0] LIMITE = 16'(DEBOUNCE_CICLOS - 1);

    logic        sinc_a;
    logic        sinc_b;
    logic [15:0] contador;
    logic        filtrado;
    logic        filtrado_q;
    logic        press;

    estado_t     estado;
    estado_t     estado_n;
    logic [31:0] dado_n;
    logic        valido_n;

    // Synchronizer and debounce filter.
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_a     <= 1'b0;
            sinc_b     <= 1'b0;
            contador   <= '0;
            filtrado   <= 1'b0;
            filtrado_q <= 1'b0;
        end else begin
            sinc_a     <= botaoIN;
            sinc_b     <= sinc_a;
            filtrado_q <= filtrado;
            if (sinc_b == filtrado) begin
                contador <= '0;
            end else if (contador == LIMITE) begin
                filtrado <= ~filtrado;
                contador <= '0;
            end else begin
                contador <= contador + 16'd1;
            end
        end
    end

    // Press is the single cycle right after the filtered level rose; a
    // button already held when AGUARDA_PRESS is entered never produces it.
    assign press = filtrado & ~filtrado_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= OCIOSO;
            dado    <= '0;
            valido  <= 1'b0;
            status  <= 1'b0;
            liberar <= 1'b0;
        end else begin
            estado  <= estado_n;
            dado    <= dado_n;
            valido  <= valido_n;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            status  <= (estado_n == AGUARDA_PRESS) ||
                       (estado_n == AGUARDA_SOLTA);
            liberar <= (estado_n == LIBERA);
        end
    end

    always_comb begin
        estado_n = estado;
        dado_n   = dado;
        valido_n = valido;
        unique case (estado)
            OCIOSO: begin
                if (pedido) begin
                    estado_n = AGUARDA_PRESS;
                    valido_n = 1'b0;
                end
            end
            AGUARDA_PRESS: begin
                if (!pedido) begin
                    estado_n = OCIOSO;
                end else if (press) begin
                    estado_n = AGUARDA_SOLTA;
                    dado_n   = 32'(chaves);
                    valido_n = 1'b1;
                end
            end
            AGUARDA_SOLTA: begin
                if (!filtrado) begin
                    estado_n = LIBERA;
                end
            end
            LIBERA: begin
                estado_n = CONCLUIDO;
            end
            CONCLUIDO: begin
                if (!pedido) begin
                    estado_n = OCIOSO;
                end
            end
            default: begin
                estado_n = OCIOSO;
            end
        endcase
    end

endmodule

// File: tb/tb_controle_entrada.sv
// tb_controle_entrada: scoreboard bench for controle_entrada.
// Directed scenarios with DEBOUNCE_CICLOS=4, LARGURA_CHAVES=16.
module tb_controle_entrada;

    logic        clock = 1'b0;
    logic        reset;
    logic        pedido;
    logic        botaoIN;
    logic [15:0] chaves;
    logic [31:0] dado;
    logic        valido;
    logic        status;
    logic        liberar;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          lib;
        logic [31:0] valor;
    } evento_t;

    evento_t fila[$];
    logic    valido_q = 1'b0;

    controle_entrada #(
        .DEBOUNCE_CICLOS(4),
        .LARGURA_CHAVES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pedido(pedido),
        .botaoIN(botaoIN),
        .chaves(chaves),
        .dado(dado),
        .valido(valido),
        .status(status),
        .liberar(liberar)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] atual,
                         input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nome, atual, esperado);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic espera_captura(input logic [31:0] v);
        evento_t e;
        e.lib = 1'b0;
        e.valor = v;
        fila.push_back(e);
        e.lib = 1'b1;
        e.valor = '0;
        fila.push_back(e);
    endtask

    task automatic mon_evento(input bit lib, input logic [31:0] v);
        evento_t e;
        if (fila.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got lib=%0d dado=%h, expected none",
                     lib, v);
        end else begin
            e = fila.pop_front();
            check("event_kind", 32'(lib), 32'(e.lib));
            if (!lib) check("capture_dado", v, e.valor);
        end
    endtask

    // Monitor: every capture (valido rising) and every liberar pulse must
    // match the next expected event.
    always @(negedge clock) begin
        if (valido && !valido_q) mon_evento(1'b0, dado);
        if (liberar) mon_evento(1'b1, 32'h0);
        valido_q = valido;
    end

    initial begin
        reset = 1'b1;
        pedido = 1'b0;
        botaoIN = 1'b0;
        chaves = 16'h0;
        tick(3);
        reset = 1'b0;
        check("rst_dado", dado, 32'h0);
        check("rst_valido", 32'(valido), 32'h0);
        check("rst_status", 32'(status), 32'h0);
        check("rst_liberar", 32'(liberar), 32'h0);

        // Normal request
        pedido = 1'b1;
        chaves = 16'hA5C3;
        tick(1);
        check("n_status_up", 32'(status), 32'h1);
        espera_captura(32'h0000A5C3);
        botaoIN = 1'b1;
        tick(6);
        check("n_valido_early", 32'(valido), 32'h0);
        tick(1);
        check("n_valido_7", 32'(valido), 32'h1);
        check("n_dado_7", dado, 32'h0000A5C3);
        tick(3);
        botaoIN = 1'b0;
        tick(6);
        check("n_status_hold", 32'(status), 32'h1);
        check("n_lib_early", 32'(liberar), 32'h0);
        tick(1);
        check("n_lib_pulse", 32'(liberar), 32'h1);
        check("n_status_lib", 32'(status), 32'h0);
        tick(1);
        check("n_lib_end", 32'(liberar), 32'h0);
        pedido = 1'b0;
        tick(2);
        check("n_valido_kept", 32'(valido), 32'h1);

        // Bounce
        pedido = 1'b1;
        chaves = 16'h1234;
        tick(1);
        espera_captura(32'h00001234);
        for (int i = 0; i < 3; i++) begin
            botaoIN = 1'b1;
            tick(2);
            botaoIN = 1'b0;
            tick(2);
        end
        check("b_no_capture", 32'(valido), 32'h0);
        botaoIN = 1'b1;
        tick(12);
        botaoIN = 1'b0;
        tick(12);
        pedido = 1'b0;
        tick(2);
        check("b_dado", dado, 32'h00001234);

        // Held button at request
        botaoIN = 1'b1;
        tick(10);
        pedido = 1'b1;
        chaves = 16'hBEEF;
        tick(10);
        check("h_status", 32'(status), 32'h1);
        check("h_valido", 32'(valido), 32'h0);
        check("h_dado", dado, 32'h00001234);
        espera_captura(32'h0000BEEF);
        botaoIN = 1'b0;
        tick(10);
        botaoIN = 1'b1;
        tick(10);
        check("h_dado_cap", dado, 32'h0000BEEF);
        botaoIN = 1'b0;
        tick(10);
        pedido = 1'b0;
        tick(2);

        // Abort in the same cycle as the press event
        pedido = 1'b1;
        chaves = 16'h0F0F;
        tick(1);
        botaoIN = 1'b1;
        tick(6);
        pedido = 1'b0;
        tick(1);
        check("a_status", 32'(status), 32'h0);
        check("a_valido", 32'(valido), 32'h0);
        check("a_dado", dado, 32'h0000BEEF);
        tick(2);
        botaoIN = 1'b0;
        tick(10);
        check("a_liberar", 32'(liberar), 32'h0);

        // Reset in AGUARDA_SOLTA
        pedido = 1'b1;
        chaves = 16'h1111;
        tick(1);
        begin
            evento_t e;
            e.lib = 1'b0;
            e.valor = 32'h00001111;
            fila.push_back(e);
        end
        botaoIN = 1'b1;
        tick(7);
        check("r_status_pre", 32'(status), 32'h1);
        check("r_dado_pre", dado, 32'h00001111);
        reset = 1'b1;
        pedido = 1'b0;
        tick(1);
        check("r_dado", dado, 32'h0);
        check("r_valido", 32'(valido), 32'h0);
        check("r_status", 32'(status), 32'h0);
        check("r_liberar", 32'(liberar), 32'h0);
        reset = 1'b0;
        tick(3);
        botaoIN = 1'b0;
        tick(12);

        // Extra presses while held in CONCLUIDO
        pedido = 1'b1;
        chaves = 16'h2222;
        tick(1);
        espera_captura(32'h00002222);
        botaoIN = 1'b1;
        tick(10);
        botaoIN = 1'b0;
        tick(10);
        chaves = 16'h3333;
        for (int i = 0; i < 2; i++) begin
            botaoIN = 1'b1;
            tick(8);
            botaoIN = 1'b0;
            tick(8);
        end
        check("c_dado", dado, 32'h00002222);
        check("c_status", 32'(status), 32'h0);
        pedido = 1'b0;
        tick(2);
        pedido = 1'b1;
        chaves = 16'h4444;
        tick(1);
        espera_captura(32'h00004444);
        botaoIN = 1'b1;
        tick(10);
        botaoIN = 1'b0;
        tick(10);
        pedido = 1'b0;
        tick(2);
        check("c_dado_new", dado, 32'h00004444);

        tick(5);
        check("pending_events", 32'(fila.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
